// File: rtl/pe256_req_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pe256_req_decoder                                             |
// | Purpose  : Pending-request vector for a priority encoder. It accepts     |
// |            SET / CLR / TOGGLE / CLEAR_ALL commands, consumer pops, a     |
// |            one-hot decode of the last command index, and a popcount.     |
// |            CLEAR_ALL runs as a multi-cycle sliced sweep.                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pe256_req_decoder #(
  parameter int WIDTH   = 256,
  parameter int IW      = 8,
  parameter int SWEEP_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [IW-1:0]    in_idx,
  input  logic             pop_valid,
  input  logic [IW-1:0]    pop_idx,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] onehot,
  output logic             onehot_v,
  output logic             v,
  output logic [IW:0]      count
);

  localparam int c_nslice = WIDTH / SWEEP_W;
  localparam int c_sc_w   = (c_nslice > 1) ? $clog2(c_nslice) : 1;
  localparam logic [c_sc_w-1:0] c_sc_last = c_sc_w'(c_nslice - 1);

  localparam logic [1:0] c_op_set    = 2'b00;
  localparam logic [1:0] c_op_clr    = 2'b01;
  localparam logic [1:0] c_op_toggle = 2'b10;
  localparam logic [1:0] c_op_clrall = 2'b11;

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_sweep = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [c_sc_w-1:0] r_sc;
  logic [c_sc_w-1:0] w_sc_next;
  logic [WIDTH-1:0]  r_d;
  logic [WIDTH-1:0]  w_d_next;
  logic [WIDTH-1:0]  r_onehot;
  logic [WIDTH-1:0]  w_onehot_next;
  logic              r_onehot_v;
  logic              w_onehot_v_next;
  logic              w_accept;
  logic [IW:0]       w_count;

  assign in_ready = (r_state == c_idle);
  assign w_accept = in_valid & in_ready;

  // Next-state: sweep slice clear first, then pop, then the accepted command,
  // so a same-index command always acts on the post-pop bit value.
  always_comb begin
    w_d_next        = r_d;
    w_state_next    = r_state;
    w_sc_next       = r_sc;
    w_onehot_next   = r_onehot;
    w_onehot_v_next = 1'b0;

    if (r_state == c_sweep) begin
      for (int s = 0; s < c_nslice; s++) begin
        if (r_sc == c_sc_w'(s)) begin
          w_d_next[s*SWEEP_W +: SWEEP_W] = '0;
        end
      end
      if (r_sc == c_sc_last) begin
        w_state_next = c_idle;
        w_sc_next    = '0;
      end else begin
        w_sc_next = r_sc + 1'b1;
      end
    end

    if (pop_valid) begin
      w_d_next[pop_idx] = 1'b0;
    end

    if (w_accept) begin
      case (in_op)
        c_op_set:    w_d_next[in_idx] = 1'b1;
        c_op_clr:    w_d_next[in_idx] = 1'b0;
        c_op_toggle: w_d_next[in_idx] = ~w_d_next[in_idx];
        default: begin
          w_state_next = c_sweep;
          w_sc_next    = '0;
        end
      endcase
      if (in_op != c_op_clrall) begin
        w_onehot_next         = '0;
        w_onehot_next[in_idx] = 1'b1;
        w_onehot_v_next       = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_idle;
      r_sc       <= '0;
      r_d        <= '0;
      r_onehot   <= '0;
      r_onehot_v <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_sc       <= w_sc_next;
      r_d        <= w_d_next;
      r_onehot   <= w_onehot_next;
      r_onehot_v <= w_onehot_v_next;
    end
  end

  // Population count of the registered vector.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_count = w_count + (IW+1)'(r_d[i]);
    end
  end

  assign d        = r_d;
  assign onehot   = r_onehot;
  assign onehot_v = r_onehot_v;
  assign v        = |r_d;
  assign count    = w_count;

endmodule
`default_nettype wire

// File: tb/tb_pe256_req_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pe256_req_decoder                                          |
// | Purpose  : Self-checking bench for pe256_req_decoder with a behavioural  |
// |            bit-array model and directed plus random stimulus.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pe256_req_decoder;

  localparam int W   = 256;
  localparam int SW  = 32;
  localparam int NSL = W / SW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [7:0]   in_idx;
  logic         pop_valid;
  logic [7:0]   pop_idx;
  logic [W-1:0] d;
  logic [W-1:0] onehot;
  logic         onehot_v;
  logic         v;
  logic [8:0]   count;

  pe256_req_decoder #(.WIDTH(W), .IW(8), .SWEEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_idx(in_idx), .pop_valid(pop_valid), .pop_idx(pop_idx),
    .d(d), .onehot(onehot), .onehot_v(onehot_v), .v(v), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: plain bit array plus "sweep slices remaining".
  logic [W-1:0] m_d;
  logic [W-1:0] m_oh;
  logic         m_ohv;
  int           m_left;
  int           n_vec = 0;
  int           n_err = 0;
  bit           chk_en = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int msb(input logic [W-1:0] x);
    int r = -1;
    for (int i = 0; i < W; i++) if (x[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_d = '0; m_oh = '0; m_ohv = 1'b0; m_left = 0;
  endtask

  task automatic model_edge();
    bit acc = in_valid && (m_left == 0);
    if (m_left > 0) begin
      int sl = NSL - m_left;
      for (int b = 0; b < SW; b++) m_d[sl*SW + b] = 1'b0;
      m_left--;
    end
    if (pop_valid) m_d[pop_idx] = 1'b0;
    m_ohv = 1'b0;
    if (acc) begin
      if (in_op == 2'd3) begin
        m_left = NSL;
      end else begin
        if (in_op == 2'd0)      m_d[in_idx] = 1'b1;
        else if (in_op == 2'd1) m_d[in_idx] = 1'b0;
        else                    m_d[in_idx] = ~m_d[in_idx];
        m_oh = '0;
        m_oh[in_idx] = 1'b1;
        m_ohv = 1'b1;
      end
    end
  endtask

  // Drive at negedge, model the rising edge, return at the next negedge.
  task automatic step(input logic vl, input logic [1:0] op, input logic [7:0] ix,
                      input logic pv, input logic [7:0] pi);
    in_valid = vl; in_op = op; in_idx = ix; pop_valid = pv; pop_idx = pi;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d", d, m_d);
      chk("onehot", onehot, m_oh);
      chk("onehot_v", onehot_v, m_ohv);
      chk("in_ready", in_ready, m_left == 0);
      chk("count", count, $countones(m_d));
      chk("v", v, m_d != '0);
    end
  end

  logic [W-1:0] e1;
  int           low;
  logic         hv;
  logic [1:0]   hop;
  logic [7:0]   hix;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_idx = 8'd0;
    pop_valid = 1'b0; pop_idx = 8'd0;
    model_reset();
    #2;
    chk("rst_ready", in_ready, 1);
    chk("rst_v", v, 0);
    chk("rst_count", count, 0);
    chk("rst_d", d, 0);
    chk_en = 1;
    @(negedge clk);
    rst_n = 1'b1;

    // Walk a single SET/CLR across every index.
    for (int i = 0; i < W; i++) begin
      step(1, 2'd0, i[7:0], 0, 8'd0);
      e1 = '0; e1[i] = 1'b1;
      chk("walk_set_d", d, e1);
      chk("walk_set_oh", onehot, e1);
      chk("walk_set_ohv", onehot_v, 1);
      chk("walk_set_cnt", count, 1);
      step(1, 2'd1, i[7:0], 0, 8'd0);
      chk("walk_clr_d", d, 0);
      chk("walk_clr_v", v, 0);
    end

    // Encoder view of d.
    step(1, 2'd0, 8'd5, 0, 8'd0);
    step(1, 2'd0, 8'd123, 0, 8'd0);
    step(1, 2'd0, 8'd200, 0, 8'd0);
    chk("enc_cnt3", count, 3);
    chk("enc_q200", msb(d), 200);
    step(0, 2'd0, 8'd0, 1, 8'd200);
    chk("enc_cnt2", count, 2);
    chk("enc_q123", msb(d), 123);
    chk("pop_ohv0", onehot_v, 0);
    step(1, 2'd1, 8'd5, 0, 8'd0);
    step(1, 2'd1, 8'd123, 0, 8'd0);

    // Same-edge command and pop.
    step(1, 2'd0, 8'd77, 1, 8'd77);
    chk("same_set_pop", d[77], 1);
    step(1, 2'd2, 8'd77, 1, 8'd77);
    chk("same_tog_pop", d[77], 1);
    step(1, 2'd0, 8'd10, 0, 8'd0);
    step(1, 2'd0, 8'd20, 0, 8'd0);
    step(1, 2'd1, 8'd10, 1, 8'd20);
    chk("diff_clr10", d[10], 0);
    chk("diff_pop20", d[20], 0);

    // Fill, then sweep with a held command that must be ignored.
    for (int i = 0; i < W; i++) step(1, 2'd0, i[7:0], 0, 8'd0);
    chk("full_cnt", count, 256);
    step(1, 2'd3, 8'd0, 0, 8'd0);
    chk("clrall_ohv", onehot_v, 0);
    low = 0;
    while (!in_ready && low < 20) begin
      low++;
      step(1, 2'd1, 8'd3, 0, 8'd0);
      if (low == 1) chk("sweep_first", d[31:0], 0);
    end
    chk("sweep_len", low, 8);
    chk("sweep_done_d", d, 0);
    step(0, 2'd0, 8'd0, 0, 8'd0);

    // Reset in the middle of a sweep, checked before any clock edge.
    step(1, 2'd0, 8'd40, 0, 8'd0);
    step(1, 2'd0, 8'd250, 0, 8'd0);
    step(1, 2'd3, 8'd0, 0, 8'd0);
    step(0, 2'd0, 8'd0, 0, 8'd0);
    step(0, 2'd0, 8'd0, 0, 8'd0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_d", d, 0);
    chk("async_ready", in_ready, 1);
    chk("async_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 2'd0, 8'd9, 0, 8'd0);
    e1 = '0; e1[9] = 1'b1;
    chk("first_after_rst", d, e1);

    // Random commands and pops; commands are held while not ready.
    hv = 1'b0; hop = 2'd0; hix = 8'd0;
    for (int n = 0; n < 1000; n++) begin
      if (m_left == 0 || !hv) begin
        hv  = ($urandom_range(0, 3) != 0);
        hop = ($urandom_range(0, 24) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        hix = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      end
      step(hv, hop, hix, ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)));
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe256_req_decoder.md
PE256_REQ_DECODER -- requirements
Module: pe256_req_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 256, giving the request vector width.
REQ-002 SHALL have parameter IW, default 8, giving the index width; IW SHALL equal log2(WIDTH).
REQ-003 SHALL have parameter SWEEP_W, default 32, giving the bits cleared per cycle during a sweep; WIDTH SHALL be a multiple of SWEEP_W.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  command valid.
REQ-007 in_ready  output  1  command accepted when in_valid and in_ready are both high at a rising edge.
REQ-008 in_op  input  2  command opcode: 00 SET, 01 CLR, 10 TOGGLE, 11 CLEAR_ALL.
REQ-009 in_idx  input  IW  target bit index; ignored for CLEAR_ALL.
REQ-010 pop_valid  input  1  consumer clear request, always accepted.
REQ-011 pop_idx  input  IW  index to clear, normally the encoder's q output.
REQ-012 d  output  WIDTH  registered pending-request vector, which drives the priority encoder's d input.
REQ-013 onehot  output  WIDTH  registered one-hot decode of the last accepted in_idx.
REQ-014 onehot_v  output  1  onehot is valid this cycle.
REQ-015 v  output  1  OR-reduction of d.
REQ-016 count  output  IW+1  population count of d, combinational from the d register.

Function
REQ-017 The FSM SHALL have exactly two states: IDLE and SWEEP.
REQ-018 in_ready SHALL be 1 in IDLE and 0 in SWEEP.
REQ-019 In IDLE, an accepted SET SHALL set d[in_idx] to 1 at the same edge.
REQ-020 In IDLE, an accepted CLR SHALL set d[in_idx] to 0 at the same edge.
REQ-021 In IDLE, an accepted TOGGLE SHALL invert d[in_idx] at the same edge.
REQ-022 An accepted SET, CLR or TOGGLE SHALL load onehot with 1 shifted left by in_idx and set onehot_v to 1 at the same edge; latency from acceptance to d/onehot change is 1 edge.
REQ-023 onehot_v SHALL be 0 in any cycle following an edge with no accepted SET, CLR or TOGGLE; onehot SHALL hold its previous value.
REQ-024 pop_valid SHALL clear d[pop_idx] at the edge, in both IDLE and SWEEP.
REQ-025 Same edge, same index: the command SHALL be applied after the pop, so SET wins (bit = 1), CLR gives 0, and TOGGLE acts on the post-pop value (bit = 1).
REQ-026 Same edge, different indices: both updates SHALL take effect.
REQ-027 An accepted CLEAR_ALL SHALL move the FSM to SWEEP and set the sweep counter to 0; d and onehot SHALL be unchanged at that edge, and onehot_v SHALL be 0.
REQ-028 In SWEEP, each edge SHALL clear d[sc*SWEEP_W +: SWEEP_W] and increment the sweep counter sc.
REQ-029 After the slice with sc = WIDTH/SWEEP_W - 1 (8 edges at the defaults), the FSM SHALL return to IDLE; in_ready SHALL be 1 in the following cycle.
REQ-030 Commands presented while in_ready = 0 SHALL be ignored, and the source SHALL hold them until accepted.
REQ-031 in_idx and pop_idx out of range SHALL be impossible by width (IW = log2 WIDTH); no wrap handling is required.
REQ-032 count SHALL range 0 to WIDTH; the value WIDTH SHALL be representable.
REQ-033 v SHALL equal (count != 0) in every cycle.

Reset
REQ-034 Asserting rst_n low SHALL immediately force d = 0, onehot = 0, onehot_v = 0, FSM = IDLE and sweep counter = 0.
REQ-035 During reset, in_ready SHALL be 1, v SHALL be 0 and count SHALL be 0.
REQ-036 Reset asserted mid-SWEEP SHALL abort the sweep; after release, the block SHALL be in IDLE with an empty d.
REQ-037 The first command after reset release SHALL be accepted at the first rising edge where rst_n = 1 and in_valid = 1.

Verification
REQ-038 Reset, then SET for idx 0..255 in turn, each followed by CLR -> after each SET: d equals 1 shifted left by idx, onehot equals d, onehot_v = 1, count = 1; after each CLR: d = 0, v = 0.
REQ-039 SET 5, 123, 200 -> count = 3; the encoder fed by d gives q = 200; then pop 200 -> count = 2, encoder q = 123.
REQ-040 Same-cycle SET 77 and pop 77 -> d[77] = 1; same-cycle CLR 10 and pop 20 with both bits previously set -> both bits 0.
REQ-041 Set all 256 bits, then CLEAR_ALL -> in_ready = 0 for exactly 8 cycles; d[31:0] = 0 after the first sweep edge; d = 0 and in_ready = 1 after the 8th sweep edge; count = 256 before the sweep.
REQ-042 Assert rst_n low at the 3rd sweep cycle -> d = 0 and in_ready = 1 immediately, without waiting for a clock edge.
REQ-043 Apply 1000 random cycles of commands and pops, checking against a reference model -> d, count and v SHALL match the model every cycle, with zero mismatches.
